// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM receive demultiplexer: FSM state encoding
// and the slot-index width helper.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Bits needed to hold a slot index 0..n-1, never less than one.
  function automatic int slot_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-NCH slot counter with load-to-1, clear and increment controls.
// Clear wins over load, load wins over increment.
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter  int NCH    = 4,
  localparam int SLOT_W = slot_w(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load1,
  input  logic              clr,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NCH - 1);
  localparam logic [SLOT_W-1:0] ONE       = SLOT_W'(1);

  assign last = (slot == LAST_SLOT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= ONE;
    end else if (inc) begin
      slot <= last ? '0 : slot + ONE;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: locks onto FSYNC frame alignment, collects one
// word per slot and presents each complete frame on a parallel bus.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter  int NCH    = 4,
  parameter  int W      = 8,
  localparam int SLOT_W = slot_w(NCH)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [W-1:0]        DIN,
  input  logic                DIN_VLD,
  input  logic                FSYNC,
  output logic [NCH*W-1:0]    DOUT,
  output logic                DOUT_VLD,
  output logic                LOCKED,
  output logic                SYNC_ERR,
  output logic [SLOT_W-1:0]   SLOT
);

  state_t                 state;
  state_t                 state_nxt;
  logic [SLOT_W-1:0]      slot;
  logic                   last_slot;

  logic                   cnt_load1;
  logic                   cnt_clr;
  logic                   cnt_inc;
  logic                   store_slot0;
  logic                   store_mid;
  logic                   capture;
  logic                   err;

  logic [(NCH-1)*W-1:0]   shadow_p0;
  logic [NCH*W-1:0]       dout_p1;
  logic                   dout_vld_p1;
  logic                   sync_err_p1;

  tdm_slot_counter #(
    .NCH (NCH)
  ) u_slot_counter (
    .clk   (CLK),
    .rst_n (RST_N),
    .load1 (cnt_load1),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .slot  (slot),
    .last  (last_slot)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (DIN_VLD) begin
      unique case (state)
        HUNT:    if (FSYNC) state_nxt = LOCK;
        LOCK:    if (!FSYNC && (slot == '0)) state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  // An FSYNC in LOCK always restarts the frame at slot 0; it is only an
  // error when it interrupts a partially collected frame.
  always_comb begin
    cnt_load1   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    store_slot0 = 1'b0;
    store_mid   = 1'b0;
    capture     = 1'b0;
    err         = 1'b0;
    if (DIN_VLD) begin
      unique case (state)
        HUNT: begin
          if (FSYNC) begin
            store_slot0 = 1'b1;
            cnt_load1   = 1'b1;
          end
        end
        LOCK: begin
          if (FSYNC) begin
            store_slot0 = 1'b1;
            cnt_load1   = 1'b1;
            err         = (slot != '0);
          end else if (slot == '0) begin
            err     = 1'b1;
            cnt_clr = 1'b1;
          end else if (last_slot) begin
            capture = 1'b1;
            cnt_inc = 1'b1;
          end else begin
            store_mid = 1'b1;
            cnt_inc   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0 -> p1: shadow collects slots 0..NCH-2, the final word completes
  // the frame so DOUT only ever changes as a whole.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_p0   <= '0;
      dout_p1     <= '0;
      dout_vld_p1 <= 1'b0;
      sync_err_p1 <= 1'b0;
    end else begin
      dout_vld_p1 <= capture;
      sync_err_p1 <= err;
      if (store_slot0) shadow_p0[0 +: W] <= DIN;
      for (int k = 1; k < NCH - 1; k++) begin
        if (store_mid && (slot == SLOT_W'(k))) shadow_p0[k*W +: W] <= DIN;
      end
      if (capture) dout_p1 <= {DIN, shadow_p0};
    end
  end

  assign DOUT     = dout_p1;
  assign DOUT_VLD = dout_vld_p1;
  assign SYNC_ERR = sync_err_p1;
  assign LOCKED   = (state == LOCK);
  assign SLOT     = slot;

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: directed frames plus randomized traffic
// checked against a frame-level reference model.
module tb_tdm_demux;

  localparam int NCH    = 4;
  localparam int W      = 8;
  localparam int SLOT_W = 2;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [W-1:0]      DIN;
  logic              DIN_VLD;
  logic              FSYNC;
  logic [NCH*W-1:0]  DOUT;
  logic              DOUT_VLD;
  logic              LOCKED;
  logic              SYNC_ERR;
  logic [SLOT_W-1:0] SLOT;

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .DIN      (DIN),
    .DIN_VLD  (DIN_VLD),
    .FSYNC    (FSYNC),
    .DOUT     (DOUT),
    .DOUT_VLD (DOUT_VLD),
    .LOCKED   (LOCKED),
    .SYNC_ERR (SYNC_ERR),
    .SLOT     (SLOT)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: frame words collected so far, lock flag, last frame.
  bit               m_locked;
  logic [W-1:0]     frame_q[$];
  logic [NCH*W-1:0] m_dout;
  logic [NCH*W-1:0] exp_q[$];
  int               err_pend;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    m_locked = 1'b0;
    frame_q.delete();
    exp_q.delete();
    m_dout   = '0;
    err_pend = 0;
  endfunction

  function automatic void model_step(input bit vld, input bit fs, input logic [W-1:0] d);
    logic [NCH*W-1:0] f;
    if (!vld) return;
    if (!m_locked) begin
      if (fs) begin
        frame_q.delete();
        frame_q.push_back(d);
        m_locked = 1'b1;
      end
    end else if (fs) begin
      if (frame_q.size() != 0) err_pend++;
      frame_q.delete();
      frame_q.push_back(d);
    end else if (frame_q.size() == 0) begin
      err_pend++;
      m_locked = 1'b0;
    end else begin
      frame_q.push_back(d);
      if (frame_q.size() == NCH) begin
        f = '0;
        for (int k = 0; k < NCH; k++) f[k*W +: W] = frame_q[k];
        exp_q.push_back(f);
        m_dout = f;
        frame_q.delete();
      end
    end
  endfunction

  task automatic send(input bit vld, input bit fs, input logic [W-1:0] d);
    DIN_VLD = vld;
    FSYNC   = fs;
    DIN     = d;
    @(posedge CLK);
    model_step(vld, fs, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b1, W'($urandom));
  endtask

  task automatic frame(input logic [W-1:0] base);
    for (int k = 0; k < NCH; k++) send(1'b1, k == 0, base + W'(k));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"},     DOUT, 0);
    check({tag, "_dout_vld"}, DOUT_VLD, 0);
    check({tag, "_locked"},   LOCKED, 0);
    check({tag, "_sync_err"}, SYNC_ERR, 0);
    check({tag, "_slot"},     SLOT, 0);
  endtask

  // Called 1 time unit after a rising edge; asserts reset between edges.
  task automatic async_reset(input string tag);
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_reset_outputs(tag);
    DIN_VLD = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      check("dout_vld", DOUT_VLD, exp_q.size() != 0);
      if (DOUT_VLD && exp_q.size() != 0) check("dout_frame", DOUT, exp_q.pop_front());
      exp_q.delete();
      check("sync_err", SYNC_ERR, err_pend != 0);
      err_pend = 0;
      check("locked", LOCKED, m_locked);
      check("slot", SLOT, m_locked ? frame_q.size() : 0);
      check("dout_hold", DOUT, m_dout);
    end
  end

  initial begin
    bit fs;
    bit vld;
    RST_N   = 1'b0;
    DIN     = '0;
    DIN_VLD = 1'b0;
    FSYNC   = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    idle(2);

    // Lock and first frame
    send(1'b1, 1'b0, 8'h11);
    frame(8'hA0);
    idle(2);
    check("first_frame", DOUT, 32'hA3A2A1A0);

    // Gapped input
    send(1'b1, 1'b1, 8'hA0); idle(1);
    send(1'b1, 1'b0, 8'hA1); idle(2);
    send(1'b1, 1'b0, 8'hA2); idle(3);
    send(1'b1, 1'b0, 8'hA3); idle(2);

    // Early FSYNC
    send(1'b1, 1'b1, 8'hB0);
    send(1'b1, 1'b0, 8'hB1);
    frame(8'hC0);
    idle(2);
    check("early_sync_frame", DOUT, 32'hC3C2C1C0);

    // Missing FSYNC, then relock
    frame(8'hE0);
    send(1'b1, 1'b0, 8'hD0);
    send(1'b1, 1'b0, 8'hD1);
    idle(1);
    check("missing_sync_hold", DOUT, 32'hE3E2E1E0);
    frame(8'h50);
    idle(1);

    // Continuous stream
    frame(8'h10);
    frame(8'h20);
    frame(8'h30);
    idle(2);

    // Reset mid-frame
    send(1'b1, 1'b1, 8'h70);
    send(1'b1, 1'b0, 8'h71);
    async_reset("mid_reset");
    idle(1);

    // Randomized traffic with occasional sync faults and resets
    for (int i = 0; i < 3000; i++) begin
      vld = ($urandom_range(0, 9) < 7);
      fs  = m_locked ? (frame_q.size() == 0) : ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) fs = ~fs;
      send(vld, fs, W'($urandom));
      if ($urandom_range(0, 499) == 0) async_reset("rand_reset");
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
